// File: rtl/mux_sel_arbiter_pkg.sv
// Shared definitions for the 2:1 mux select arbiter: FSM state encodings
// and the state enum used by the top level and the bench.
package mux_sel_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_OWN0 = ST_OWN0,
        S_OWN1 = ST_OWN1
    } state_t;

endpackage

// File: rtl/mux_sel_arbiter_hold_timer.sv
// Ownership hold counter: counts granted cycles and flags the last allowed
// cycle so the arbiter can force a release.
module hold_timer #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             expire
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign cnt    = cnt_reg;
    assign expire = (cnt_reg == LAST_CNT);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a 2:1 data mux. Grants are
// break-before-make: every release passes through one idle cycle.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic done,
    output logic gnt0,
    output logic gnt1,
    output logic sel,
    output logic busy,
    output logic timeout
);

    state_t           state_reg;
    logic             last_reg;
    logic             gnt0_reg;
    logic             gnt1_reg;
    logic             sel_reg;
    logic             busy_reg;
    logic             timeout_reg;

    logic             own_req;
    logic             release_own;
    logic             timer_clear;
    logic             timer_enable;
    logic             expire;
    logic [CNT_W-1:0] cnt;

    hold_timer #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .cnt    (cnt),
        .expire (expire)
    );

    always_comb begin
        own_req      = (state_reg == S_OWN1) ? req1 : req0;
        release_own  = (state_reg != S_IDLE) && (done || !own_req || expire);
        timer_clear  = (state_reg == S_IDLE) || release_own;
        timer_enable = (state_reg != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            last_reg    <= 1'b1;
            gnt0_reg    <= 1'b0;
            gnt1_reg    <= 1'b0;
            sel_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // On a tie the requester that did not own last wins.
                    if (req0 && (!req1 || last_reg)) begin
                        state_reg <= S_OWN0;
                        gnt0_reg  <= 1'b1;
                        busy_reg  <= 1'b1;
                        sel_reg   <= 1'b0;
                        last_reg  <= 1'b0;
                    end else if (req1) begin
                        state_reg <= S_OWN1;
                        gnt1_reg  <= 1'b1;
                        busy_reg  <= 1'b1;
                        sel_reg   <= 1'b1;
                        last_reg  <= 1'b1;
                    end
                end
                default: begin
                    if (release_own) begin
                        state_reg   <= S_IDLE;
                        gnt0_reg    <= 1'b0;
                        gnt1_reg    <= 1'b0;
                        busy_reg    <= 1'b0;
                        // Only a pure hold-timer release flags a timeout.
                        timeout_reg <= expire && !done && own_req;
                    end
                end
            endcase
        end
    end

    assign gnt0    = gnt0_reg;
    assign gnt1    = gnt1_reg;
    assign sel     = sel_reg;
    assign busy    = busy_reg;
    assign timeout = timeout_reg;

endmodule
